// File: rtl/uart_tx_buffer.sv
// -----------------------------------------------------------------------------
// uart_tx_buffer
//
// Byte FIFO and issue controller placed directly in front of the UART
// transmitter. The core pushes bytes at full clock rate. A small FSM hands
// the bytes to the transmitter one at a time over its data/ok/busy handshake.
//
// Parameters
//   DEPTH    FIFO capacity in bytes (power of two, >= 2)
//   PTR_W    pointer width, derived from DEPTH (do not override)
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous reset, active low
//   wr_data   in   byte from core
//   wr_en     in   write strobe, one byte per cycle
//   full      out  FIFO holds DEPTH bytes
//   empty     out  FIFO holds 0 bytes
//   count     out  bytes currently queued
//   overflow  out  sticky: a write was dropped because the FIFO was full
//   drained   out  FIFO empty, controller idle and transmitter not busy
//   tx_data   out  byte to transmitter (held outside ISSUE)
//   tx_ok     out  one-cycle issue pulse to transmitter
//   tx_busy   in   transmitter busy
// -----------------------------------------------------------------------------
module uart_tx_buffer #(
   parameter int DEPTH = 16,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       wr_data,
   input  logic             wr_en,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   count,
   output logic             overflow,
   output logic             drained,
   output logic [7:0]       tx_data,
   output logic             tx_ok,
   input  logic             tx_busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [1:0]       state;
   logic             do_write;
   logic             do_pop;

   assign full  = (count == CNT_FULL);
   assign empty = (count == '0);

   // full is taken from the pre-edge count, so a write into a full FIFO is
   // dropped even when the controller pops in the same cycle.
   assign do_write = wr_en && !full;
   assign do_pop   = (state == ST_IDLE) && !empty && !tx_busy;

   assign drained = empty && (state == ST_IDLE) && !tx_busy;

   // NOTE: the storage array has no reset branch on purpose; a reset of every
   // entry would turn the array into flops with reset muxes and buys nothing,
   // since count guards against reading stale entries.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // NOTE: all state is updated with non-blocking assignments so every block
   // sees the pre-edge values of count/state regardless of evaluation order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_write) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         case ({do_write, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Issue controller. tx_busy is already high when DRAIN is entered because
   // the transmitter leaves its waiting state on the ISSUE edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         tx_data <= 8'h00;
         tx_ok   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (do_pop) begin
                  tx_data <= mem[rd_ptr];
                  tx_ok   <= 1'b1;
                  state   <= ST_ISSUE;
               end else begin
                  tx_ok <= 1'b0;
               end
            end
            ST_ISSUE: begin
               tx_ok <= 1'b0;
               state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               tx_ok <= 1'b0;
               if (!tx_busy) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               tx_ok <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
